// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard control bundle: hazard inputs from ID/EX plus the stage-register
// enables/flushes, debug state and performance counters driven back by the controller.
interface hazard_stall_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              IDEX_MemRead;
  logic [4:0]        IDEX_Rt;
  logic [4:0]        IFID_Rs;
  logic [4:0]        IFID_Rt;
  logic              IFID_UsesRt;
  logic              EX_BranchTaken;
  logic              MulDiv_Start;
  logic              PCWrite;
  logic              IFID_WriteEnable;
  logic              IFID_Flush;
  logic              IDEX_WriteEnable;
  logic              IDEX_Flush;
  logic [1:0]        State;
  logic [PERF_W-1:0] StallCount;
  logic [PERF_W-1:0] FlushCount;

  modport master (
    output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, EX_BranchTaken, MulDiv_Start,
    input  PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_WriteEnable, IDEX_Flush,
    input  State, StallCount, FlushCount
  );

  modport slave (
    input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, EX_BranchTaken, MulDiv_Start,
    output PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_WriteEnable, IDEX_Flush,
    output State, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for IF/ID, ID/EX and PC: load-use bubbles, taken-branch flushes,
// multicycle MUL/DIV hold. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int PERF_W        = 32
) (
  input logic               Clock,
  input logic               Reset,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MDWAIT  = 2'd2
  } state_t;

  localparam logic [7:0] MD_INIT = 8'(MULDIV_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       load_use;
  logic       pc_write, ifid_we, ifid_flush, idex_we, idex_flush;
  logic       branch_flush;

  assign load_use = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
                    ((hz.IDEX_Rt == hz.IFID_Rs) ||
                     (hz.IFID_UsesRt && (hz.IDEX_Rt == hz.IFID_Rt)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_flush   = 1'b0;
    branch_flush = 1'b0;
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    if (Reset) begin
      pc_write   = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_next = RUN;
      cnt_next   = 8'd0;
    end else begin
      case (state_reg)
        LDSTALL: state_next = RUN;
        MDWAIT: begin
          pc_write = 1'b0;
          ifid_we  = 1'b0;
          idex_we  = 1'b0;
          if (cnt_reg != 8'd0) cnt_next = cnt_reg - 8'd1;
          else                 state_next = RUN;
        end
        default: begin
          // Unused code 3 behaves as RUN and falls back to it.
          state_next = RUN;
          if (hz.EX_BranchTaken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            branch_flush = 1'b1;
          end else if (hz.MulDiv_Start) begin
            state_next = MDWAIT;
            cnt_next   = MD_INIT;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            state_next = LDSTALL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= RUN;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign hz.PCWrite          = pc_write;
  assign hz.IFID_WriteEnable = ifid_we;
  assign hz.IFID_Flush       = ifid_flush;
  assign hz.IDEX_WriteEnable = idex_we;
  assign hz.IDEX_Flush       = idex_flush;
  assign hz.State            = state_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_cnt_reg [2];
  logic [1:0]        perf_inc;

  assign perf_inc = {branch_flush, ~pc_write};

  // Index 0 counts stalled cycles, index 1 counts branch flushes; both saturate.
  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    always_ff @(posedge Clock) begin
      if (Reset)
        perf_cnt_reg[gi] <= '0;
      else if (perf_inc[gi] && (perf_cnt_reg[gi] != {PERF_W{1'b1}}))
        perf_cnt_reg[gi] <= perf_cnt_reg[gi] + PERF_W'(1);
    end
  end

  assign hz.StallCount = perf_cnt_reg[0];
  assign hz.FlushCount = perf_cnt_reg[1];
`else
  assign hz.StallCount = {PERF_W{1'b0}};
  assign hz.FlushCount = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed hazard scenarios then random traffic, each cycle
// compared with a remaining-cycles model of the pipeline control rules.
module tb_hazard_stall_ctrl;
  localparam int MDC = 4;
  localparam int PW  = 32;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  hazard_stall_ctrl_if #(.PERF_W(PW)) hz ();

  hazard_stall_ctrl #(.MULDIV_CYCLES(MDC), .PERF_W(PW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: cycles of MUL/DIV hold still owed, whether a bubble cycle follows, event counts.
  int          md_left    = 0;
  bit          ld_pending = 0;
  logic [31:0] m_stalls   = 0;
  logic [31:0] m_flushes  = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs and state, advance the model.
  task automatic step(input bit rst, input bit mr, input logic [4:0] ex_rt,
                      input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                      input bit br, input bit md);
    logic [4:0]  exp_ctl;
    logic [4:0]  got_ctl;
    logic [31:0] exp_st, exp_sc, exp_fc;
    bit          lu;
    @(negedge Clock);
    Reset             = rst;
    hz.IDEX_MemRead   = mr;
    hz.IDEX_Rt        = ex_rt;
    hz.IFID_Rs        = rs;
    hz.IFID_Rt        = rt;
    hz.IFID_UsesRt    = urt;
    hz.EX_BranchTaken = br;
    hz.MulDiv_Start   = md;
    #1;
    lu     = mr && (ex_rt != 0) && (ex_rt == rs || (urt && ex_rt == rt));
    exp_st = (md_left > 0) ? 32'd2 : (ld_pending ? 32'd1 : 32'd0);
    // Bit order {PCWrite, IFID_WE, IFID_Flush, IDEX_WE, IDEX_Flush}.
    exp_ctl = 5'b11010;
    if (rst)                exp_ctl = 5'b00101;
    else if (md_left > 0)   exp_ctl = 5'b00000;
    else if (!ld_pending) begin
      if (br)               exp_ctl = 5'b11111;
      else if (md)          exp_ctl = 5'b11010;
      else if (lu)          exp_ctl = 5'b00011;
    end
`ifdef HAZARD_PERF_CNT_EN
    exp_sc = m_stalls;
    exp_fc = m_flushes;
`else
    exp_sc = 32'd0;
    exp_fc = 32'd0;
`endif
    got_ctl = {hz.PCWrite, hz.IFID_WriteEnable, hz.IFID_Flush, hz.IDEX_WriteEnable, hz.IDEX_Flush};
    check_value("ctl", 32'(got_ctl), 32'(exp_ctl));
    check_value("state", 32'(hz.State), exp_st);
    check_value("stall_cnt", hz.StallCount, exp_sc);
    check_value("flush_cnt", hz.FlushCount, exp_fc);
    $display("cyc=%0d rst=%0b mr=%0b exrt=%0d rs=%0d rt=%0d urt=%0b br=%0b md=%0b ctl=%b st=%0d",
             cyc, rst, mr, ex_rt, rs, rt, urt, br, md, got_ctl, hz.State);
    if (rst) begin
      md_left = 0; ld_pending = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (exp_ctl[4] == 1'b0 && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (md_left > 0) md_left--;
      else if (ld_pending) ld_pending = 0;
      else if (br) begin
        if (m_flushes != 32'hFFFF_FFFF) m_flushes++;
      end
      else if (md) md_left = MDC;
      else if (lu) ld_pending = 1;
    end
    cyc++;
  endtask

  initial begin
    hz.IDEX_MemRead = 0; hz.IDEX_Rt = 0; hz.IFID_Rs = 0; hz.IFID_Rt = 0;
    hz.IFID_UsesRt = 0; hz.EX_BranchTaken = 0; hz.MulDiv_Start = 0;

    // Reset held, then release.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs; hazard inputs persist through the bubble cycle.
    step(0, 1, 5, 5, 0, 0, 0, 0);
    step(0, 1, 5, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // No hazard: rt is zero, or rt unused; then rt used.
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 5, 3, 5, 0, 0, 0);
    step(0, 1, 5, 3, 5, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // MUL/DIV hold with a branch pulse mid-wait.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 5, 5, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Reset in the second MDWAIT cycle aborts the hold.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Branch together with a true load-use: branch wins.
    step(0, 1, 7, 7, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 3,
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
